// File: rtl/ps2_pkg.sv
// Shared constants and frame check for the PS/2 keyboard receiver.
// Scan-code prefixes are exported for the downstream key-event decoder.
package ps2_pkg;
   localparam int PS2_FRAME_BITS     = 11;
   localparam int DEF_FIFO_AW        = 3;
   localparam int DEF_TIMEOUT_CYCLES = 50000;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXTEND = 8'hE0;

   // bits[0] = start, bits[8:1] = data LSB-first, bits[9] = odd parity
   function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
      return ~bits[0] & stop & (^bits[9:1]);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          w_wr;
   logic          w_rd;

   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_rd  = pop & ~empty;
   assign w_wr  = push & (~full | w_rd);
   assign rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
            r_wptr                <= r_wptr + 1'b1;
         end
         if (w_rd) r_rptr <= r_rptr + 1'b1;
      end
   end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: synchronises the pad signals,
// deserialises and validates 11-bit frames, and queues scan codes.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_AW        = DEF_FIFO_AW,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);
   localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  LAST = 4'(PS2_FRAME_BITS - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    r_s;
   logic [1:0]    r_d;
   logic [3:0]    r_cnt;
   logic [9:0]    r_buf;
   logic [TW-1:0] r_tcnt;
   logic          r_ovf;
   logic          r_ferr;

   logic w_fall, w_last, w_ok, w_push, w_pop, w_full, w_empty;

   assign w_fall = r_s[2] & ~r_s[1];
   assign w_last = w_fall && (r_cnt == LAST);
   assign w_ok   = frame_ok(r_buf, r_d[1]);
   assign w_push = w_last & w_ok;
   assign w_pop  = ~nextdata_n & ~w_empty;

   assign ready     = ~w_empty;
   assign overflow  = r_ovf;
   assign frame_err = r_ferr;

   // Sync flops idle high so reset never fabricates a falling edge
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_s <= 3'b111;
         r_d <= 2'b11;
      end else begin
         r_s <= {r_s[1:0], ps2_clk};
         r_d <= {r_d[0], ps2_data};
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt  <= '0;
         r_buf  <= '0;
         r_tcnt <= '0;
         r_ovf  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         if (w_fall) begin
            r_tcnt <= '0;
            if (r_cnt == LAST) begin
               r_cnt  <= '0;
               r_ferr <= ~w_ok;
               if (w_ok && w_full && !w_pop) r_ovf <= 1'b1;
            end else begin
               r_buf[r_cnt] <= r_d[1];
               r_cnt        <= r_cnt + 1'b1;
            end
         end else if (r_cnt == '0) begin
            r_tcnt <= '0;
         end else if (r_tcnt == TMAX) begin
            // Device stopped clocking mid-frame; resync on the next start bit
            r_tcnt <= '0;
            r_cnt  <= '0;
         end else begin
            r_tcnt <= r_tcnt + 1'b1;
         end
      end
   end

   sync_fifo #(
      .DW (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (w_push),
      .wdata (r_buf[8:1]),
      .pop   (w_pop),
      .rdata (data),
      .full  (w_full),
      .empty (w_empty)
   );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench: stimulus queues expected scan codes, a monitor checks
// every pop against the queue and tracks frame_err pulses.
module tb_ps2_keyboard_rx;
   localparam int TO = 1000;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready, overflow, frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   int exp_err = 0;
   logic exp_ovf = 1'b0;
   logic [7:0] q[$];

   ps2_keyboard_rx #(.FIFO_AW(3), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: samples mid-low-phase, away from the rising edge
   initial begin : mon
      logic prev_err;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (clrn) begin
            if (frame_err) begin
               err_seen++;
               chk("ferr_one_cycle", {31'd0, prev_err}, 32'd0);
            end
            prev_err = frame_err;
            if (!nextdata_n && ready) begin
               if (q.size() == 0) chk("pop_unexpected", {24'd0, data}, 32'hFFFF_FFFF);
               else               chk("pop_data", {24'd0, data}, {24'd0, q.pop_front()});
            end
         end else begin
            prev_err = 1'b0;
         end
      end
   end

   // One PS/2 bit, 10 clk cycles; the DUT acts on the 3rd rising edge after ps2_clk falls
   task automatic send_bit(input logic b, input bit pop_here, input bit chk_lat);
      @(negedge clk); ps2_data = b;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (pop_here) nextdata_n = 1'b0;
      if (chk_lat) begin #1; chk("ready_before_fall", {31'd0, ready}, 32'd0); end
      @(negedge clk);
      nextdata_n = 1'b1;
      if (chk_lat) begin #1; chk("ready_after_fall", {31'd0, ready}, 32'd1); end
      @(negedge clk); ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^d) ^ bad_par;
      return {~bad_stop, par, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input bit pop_last, input bit chk_lat);
      logic [10:0] f;
      f = mkframe(d, bad_par, bad_stop);
      if (bad_par || bad_stop) exp_err++;
      else if (q.size() < 8 || pop_last) q.push_back(d);
      else exp_ovf = 1'b1;
      for (int i = 0; i < 11; i++) send_bit(f[i], pop_last && i == 10, chk_lat && i == 10);
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      logic [10:0] f;
      f = mkframe(d, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) send_bit(f[i], 1'b0, 1'b0);
   endtask

   task automatic pop_n(input int n);
      @(negedge clk); nextdata_n = 1'b0;
      repeat (n) @(negedge clk);
      nextdata_n = 1'b1;
   endtask

   task automatic chk_state(input string nm, input logic exp_rdy);
      @(negedge clk); #1;
      chk({nm, "_ready"}, {31'd0, ready}, {31'd0, exp_rdy});
      chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
      chk({nm, "_errs"}, err_seen, exp_err);
   endtask

   initial begin
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);

      // 1: single frame, ready latency, single pop
      send_frame(8'h1C, 0, 0, 0, 1);
      #1 chk("t1_data", {24'd0, data}, 32'h1C);
      pop_n(1);
      chk_state("t1", 1'b0);

      // 2: break prefix then make code; extra pop while empty is ignored
      send_frame(8'hF0, 0, 0, 0, 0);
      send_frame(8'h1C, 0, 0, 0, 0);
      pop_n(1);
      pop_n(1);
      chk_state("t2", 1'b0);
      pop_n(1);
      chk_state("t2_emptypop", 1'b0);

      // 3: bad parity, bad stop
      send_frame(8'h45, 1, 0, 0, 0);
      chk_state("t3_par", 1'b0);
      send_frame(8'h45, 0, 1, 0, 0);
      chk_state("t3_stop", 1'b0);

      // 4: nine frames into an 8-deep FIFO
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 0);
      chk_state("t4_full", 1'b1);
      pop_n(8);
      chk_state("t4_drained", 1'b0);

      // 5: abandoned partial frame recovers via timeout
      send_bits(8'h33, 5);
      repeat (TO + 10) @(negedge clk);
      send_frame(8'h45, 0, 0, 0, 0);
      #1 chk("t5_data", {24'd0, data}, 32'h45);
      pop_n(1);
      chk_state("t5", 1'b0);

      // 6: reset mid-frame with entries queued and overflow set
      send_frame(8'h11, 0, 0, 0, 0);
      send_frame(8'h22, 0, 0, 0, 0);
      send_bits(8'h5A, 6);
      chk("t6_ovf_pre", {31'd0, overflow}, 32'd1);
      @(negedge clk); clrn = 1'b0;
      #1;
      chk("t6_rst_ready", {31'd0, ready}, 32'd0);
      chk("t6_rst_data", {24'd0, data}, 32'd0);
      chk("t6_rst_ovf", {31'd0, overflow}, 32'd0);
      q.delete();
      exp_ovf = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      send_frame(8'h16, 0, 0, 0, 0);
      #1 chk("t6_data", {24'd0, data}, 32'h16);
      pop_n(1);
      chk_state("t6_after", 1'b0);

      // 6b: push coinciding with a pop at full is not an overflow
      for (int i = 0; i < 8; i++) send_frame(8'hA0 + 8'(i), 0, 0, 0, 0);
      send_frame(8'hA8, 0, 0, 1, 0);
      chk_state("t6_pushpop", 1'b1);
      chk("t6_count", q.size(), 32'd8);
      pop_n(8);
      chk_state("t6_drained", 1'b0);
      chk("t6_q_empty", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver with a small show-ahead FIFO.
- Deserialises 11-bit keyboard frames (start, 8 data LSB-first, odd parity, stop) and validates each frame.
- Buffers raw scan codes (make codes, 8'hF0 break prefix, 8'hE0 extended prefix) for the downstream scan-code-to-ASCII / key-event logic, which pops them with an active-low request.

Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW (8 entries).
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge, mid-frame, before the bit counter is abandoned.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from pad; asynchronous to clk.
- ps2_data  input  1  raw PS/2 data from pad; asynchronous to clk.
- nextdata_n  input  1  active-low pop request from consumer.
- data  output  8  scan code at FIFO head; valid only while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky: a valid frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: a frame failed start, stop or parity check.

Behaviour:
- Reset is asynchronous and active-low on clrn; one clock, clk.
- Reset values: bit counter = 0, shift register = 0, read and write pointers = 0, FIFO storage = 0, ready = 0, data = 8'h00, overflow = 0, frame_err = 0, timeout counter = 0. Synchroniser flops reset to 1, the idle bus level.
- Synchronisation:
  - ps2_clk passes through 3 flops (s0, s1, s2); ps2_data passes through 2 flops (d0, d1).
  - fall = s2 & ~s1, one clk cycle per ps2_clk falling edge.
  - Bits are sampled from d1 in the fall cycle.
- Frame state: 4-bit counter cnt, 0..10.
  - On fall, bit cnt is stored into the 10-bit shift register, then cnt increments.
  - In the fall cycle with cnt = 10, the frame is evaluated and cnt returns to 0. The stop bit is the live d1 in that cycle.
  - Valid frame: start = 0, stop = 1, XOR of the 8 data bits and the parity bit = 1.
  - Valid and FIFO not full: write data byte at wptr, wptr+1.
  - Valid and FIFO full: drop the byte, set overflow. overflow stays set until clrn.
  - Invalid: no write; frame_err = 1 for exactly the next cycle.
- Timeout:
  - While cnt != 0, count clk cycles since the last fall. Reaching TIMEOUT_CYCLES forces cnt = 0.
  - No frame_err is raised on timeout. The counter clears on every fall and whenever cnt = 0.
- FIFO:
  - Pointers are FIFO_AW+1 bits wide. empty = (wptr == rptr). full = MSBs differ and the remaining bits are equal. Pointers wrap naturally.
  - ready = ~empty, registered-consistent: ready rises the cycle after the writing fall cycle.
  - Show-ahead read: data = mem[rptr[FIFO_AW-1:0]], combinational from storage.
- Pop:
  - Every rising edge with nextdata_n = 0 and ready = 1 increments rptr. Holding nextdata_n low pops one entry per cycle.
  - A pop while empty is ignored.
- Simultaneous push and pop in the same cycle:
  - Both occur and the count is unchanged.
  - When the FIFO is full, a push and pop in the same cycle is not an overflow: the pop frees a slot and the write proceeds.
- Reset mid-frame: partial frame discarded, FIFO emptied. The next frame must start from a fresh start bit.

Decomposition:
- Shared package ps2_pkg:
  - PS2_FRAME_BITS = 11.
  - Scan-code constants: SC_BREAK = 8'hF0, SC_EXTEND = 8'hE0.
  - Default FIFO_AW and TIMEOUT_CYCLES.
- Sub-module sync_fifo: parameterised by data width and address width, with push/pop/full/empty and show-ahead data. The frame deserialiser stays in the top.

Test Plan:
1. Frame for 8'h1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> frame_err stays 0; ready rises the cycle after the 11th fall; data = 8'h1C; one nextdata_n low cycle drops ready to 0.
2. Frames 8'hF0 then 8'h1C with no pops -> data = 8'hF0 first; after one pop data = 8'h1C; after a second pop ready = 0.
3. Frame 8'h45 with parity bit inverted -> frame_err high for exactly 1 cycle, ready stays 0, no pointer change. Repeat with stop bit 0 -> same response.
4. Nine valid frames 8'h01..8'h09 with no pops -> overflow = 1 after the ninth. Popping 8 times yields 8'h01..8'h08, then ready = 0.
5. Drive 5 bits, then idle ps2_clk for TIMEOUT_CYCLES+10 cycles, then a full 8'h45 frame -> data = 8'h45, no frame_err.
6. Assert clrn low after 6 bits of a frame with 2 entries queued -> ready = 0, data = 8'h00, overflow = 0 immediately. A subsequent frame 8'h16 is received correctly. Also push in the same cycle as a pop at full -> no overflow, count stays 8.
